wb_mem_tester: RTL
==================

Name: wb_mem_tester

Overview:
- Pipelined Wishbone B4 initiator that exercises the 32-bit Wishbone port of the SDRAM controller (`sdram`).
- Writes a seed-derived pattern over a region, reads it back and compares each word.
- Reports pass/fail, error count, first failing address and timeout.
- Sits in the board top beside `sdram` as a power-on/self-test master, replacing the idle stimulus the bench currently drives.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of first word tested (must be 4-byte aligned)
WORDS, 1024, number of 32-bit words tested (1..65535)
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests (1..15)
TIMEOUT, 1023, cycles without ack while requests are outstanding before abort (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse; starts a test when idle, ignored otherwise
seed_i  in  32  pattern seed, sampled on the accepted start_i cycle
busy_o  out  1  test in progress
done_o  out  1  high from test completion until next accepted start_i
pass_o  out  1  valid when done_o; 1 = zero mismatches and no timeout
timeout_o  out  1  valid when done_o; 1 = aborted on ack timeout
err_count_o  out  16  mismatch count, saturates at 16'hFFFF
first_err_addr_o  out  32  byte address of first mismatch, 0 if none
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
sel_o  out  4  byte selects, always 4'hF while stb_o
addr_o  out  32  Wishbone byte address
data_o  out  32  Wishbone write data
data_i  in  32  Wishbone read data
stall_i  in  1  Wishbone pipeline stall
ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (async, immediate): every output 0; state IDLE; all counters 0.
- Pattern: for word index k, P(k) = {~k[15:0], k[15:0]} ^ seed. Address A(k) = ADDR_BASE + 4*k, 32-bit wrap.
- States: IDLE -> WRITE -> WDRAIN -> GAP -> READ -> RDRAIN -> DONE.
- DONE returns to WRITE on start_i. DONE holds its results until the next start_i; busy_o is 0 in IDLE and DONE.
- IDLE/DONE on start_i:
  - Latch seed; clear err_count, first_err_addr, timeout_o, done_o, pass_o.
  - Enter WRITE; busy_o = 1 the next cycle.
- Issue rule (WRITE and READ):
  - stb_o = 1 while issue_idx < WORDS and outstanding < MAX_OUTSTANDING.
  - A request is accepted on a cycle with stb_o & ~stall_i; issue_idx increments on acceptance.
  - addr_o, data_o, we_o stay stable while stb_o & stall_i.
  - stb_o may be deasserted only on cycles with no acceptance pending, i.e. never during a stall.
- Outstanding counter:
  - +1 on acceptance, -1 on ack_i; unchanged when both occur in the same cycle.
  - An ack_i while outstanding == 0 is ignored and not counted.
- cyc_o:
  - Asserted together with the first stb_o of a phase.
  - Held until the cycle of the last ack of that phase.
  - Deasserted the following cycle.
- WRITE: we_o = 1, data_o = P(issue_idx). Enter WDRAIN when issue_idx == WORDS.
- WDRAIN: stb_o = 0. Enter GAP when outstanding reaches 0.
- GAP: exactly one cycle with cyc_o = 0. issue_idx and ack_idx cleared.
- READ: we_o = 0, data_o = 0.
  - Acks return in order: on each ack_i, compare data_i with P(ack_idx), then increment ack_idx.
  - On mismatch: err_count increments (saturating); if it was 0, first_err_addr = A(ack_idx).
  - Enter RDRAIN when issue_idx == WORDS.
- RDRAIN: enter DONE when outstanding reaches 0.
- DONE:
  - done_o = 1, cyc_o = 0, stb_o = 0.
  - pass_o = (err_count == 0) & ~timeout_o.
  - err_count_o and first_err_addr_o are live during the test and frozen in DONE.
- Timeout: counter clears on any ack_i or when outstanding == 0, otherwise increments.
  - On reaching TIMEOUT: drop cyc_o/stb_o, set timeout_o, enter DONE with pass_o = 0.
- Reset mid-transfer: cyc_o/stb_o drop immediately; late acks after reset are ignored.

Test Plan:
- Zero-wait slave (no stall, ack next cycle), WORDS=8, seed=0: 8 writes then 8 reads, done_o with pass_o=1, err_count_o=0. Word 3 writes 32'hFFFC_0003 to 0x0C.
- Slave stalls every other cycle and acks with 3-cycle latency: addr/data stay stable during stall; outstanding never exceeds 4; pass_o=1. Total accepts = 16, total acks = 16.
- Slave corrupts read data at byte address 0x14 and 0x18: err_count_o=2, first_err_addr_o=0x14, pass_o=0.
- Slave never acks after the 2nd write, TIMEOUT=15: cyc_o drops 15 cycles after the last ack; done_o=1, timeout_o=1, pass_o=0.
- Assert rst_i during READ with 3 outstanding: all outputs 0 immediately; an ack 1 cycle later is ignored. A new start_i runs a clean test and passes.
- start_i pulsed while busy_o=1: ignored. seed=32'hA5A5_A5A5 with WORDS=1: word 0 reads 32'h5A5A_A5A5.

Source files
------------

// File: rtl/wb_mem_tester_if.sv
// Wishbone B4 pipelined bus bundle between the memory tester (master)
// and the memory port under test (slave). Signal directions are named
// from the master's point of view.
interface wb_mem_tester_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        stall_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, addr_o, data_o,
        input  data_i, stall_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, addr_o, data_o,
        output data_i, stall_i, ack_i
    );
endinterface

// File: rtl/wb_mem_tester.sv
// Pipelined Wishbone B4 self-test master: writes a seed-derived pattern
// over a word region, reads it back in order, counts mismatches and
// records the first failing address. An ack timeout aborts the test.
module wb_mem_tester #(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int          WORDS           = 1024,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          TIMEOUT         = 1023
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [31:0]     seed_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            timeout_o,
    output logic [15:0]     err_count_o,
    output logic [31:0]     first_err_addr_o,
    wb_mem_tester_if.master wb
);
    localparam int              TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [15:0]     WORDS_L = 16'(WORDS);
    localparam logic [3:0]      MAX_L   = 4'(MAX_OUTSTANDING);
    localparam logic [TW-1:0]   TMO_L   = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_GAP,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   seed_q, seed_d;
    logic [15:0]   issue_idx_q, issue_idx_d;
    logic [15:0]   ack_idx_q, ack_idx_d;
    logic [3:0]    outst_q, outst_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   first_err_q, first_err_d;
    logic          timeout_q, timeout_d;

    logic issuing;
    logic active;
    logic reading;
    logic stb;
    logic accept;
    logic ack_cnt;

    // Expected word for index k: inverted index in the top half, index in
    // the bottom half, scrambled by the seed.
    function automatic logic [31:0] pattern(input logic [15:0] k, input logic [31:0] seed);
        return {~k, k} ^ seed;
    endfunction

    function automatic logic [31:0] word_addr(input logic [15:0] k);
        return ADDR_BASE + {14'd0, k, 2'b00};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Phase decode and request/ack qualification for the current cycle.
    always_comb begin
        issuing = (state_q == S_WRITE) || (state_q == S_READ);
        reading = (state_q == S_READ) || (state_q == S_RDRAIN);
        active  = issuing || (state_q == S_WDRAIN) || (state_q == S_RDRAIN);
        // stb only depends on registered state, so it cannot drop while a
        // stalled request waits: a stall changes neither index nor count.
        stb     = issuing && (issue_idx_q < WORDS_L) && (outst_q < MAX_L);
        accept  = stb && !wb.stall_i;
        // Acks with nothing outstanding (e.g. stragglers after a reset or
        // an abort) are dropped.
        ack_cnt = active && wb.ack_i && (outst_q != 4'd0);
    end

    // Next-state, counters and read-back comparison.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        issue_idx_d = issue_idx_q;
        ack_idx_d   = ack_idx_q;
        outst_d     = outst_q;
        tmo_d       = '0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;

        if (accept) begin
            issue_idx_d = issue_idx_q + 16'd1;
        end

        if (accept && !ack_cnt) begin
            outst_d = outst_q + 4'd1;
        end else if (!accept && ack_cnt) begin
            outst_d = outst_q - 4'd1;
        end

        // Counts only cycles that are waiting on an ack.
        if (active && !wb.ack_i && (outst_q != 4'd0)) begin
            tmo_d = tmo_q + TW'(1);
        end

        // Reads complete in order, so ack_idx names the word being returned.
        if (ack_cnt && reading) begin
            if (wb.data_i != pattern(ack_idx_q, seed_q)) begin
                if (err_cnt_q == 16'd0) begin
                    first_err_d = word_addr(ack_idx_q);
                end
                err_cnt_d = sat_inc(err_cnt_q);
            end
            ack_idx_d = ack_idx_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_WRITE;
                    seed_d      = seed_i;
                    issue_idx_d = '0;
                    ack_idx_d   = '0;
                    outst_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            S_WRITE: begin
                if (issue_idx_d == WORDS_L) begin
                    state_d = S_WDRAIN;
                end
            end
            S_WDRAIN: begin
                if (outst_d == 4'd0) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                issue_idx_d = '0;
                ack_idx_d   = '0;
                state_d     = S_READ;
            end
            S_READ: begin
                if (issue_idx_d == WORDS_L) begin
                    state_d = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                if (outst_d == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: forget outstanding requests so late acks are ignored.
        if (active && (tmo_d == TMO_L)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            outst_d   = '0;
            tmo_d     = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            issue_idx_q <= '0;
            ack_idx_q   <= '0;
            outst_q     <= '0;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            issue_idx_q <= issue_idx_d;
            ack_idx_q   <= ack_idx_d;
            outst_q     <= outst_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Bus and status outputs decoded from registered state only.
    always_comb begin
        wb.cyc_o  = active;
        wb.stb_o  = stb;
        wb.we_o   = stb && (state_q == S_WRITE);
        wb.sel_o  = stb ? 4'hF : 4'h0;
        wb.addr_o = stb ? word_addr(issue_idx_q) : 32'h0;
        wb.data_o = (stb && (state_q == S_WRITE)) ? pattern(issue_idx_q, seed_q) : 32'h0;

        busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o           = (state_q == S_DONE);
        pass_o           = (state_q == S_DONE) && (err_cnt_q == 16'd0) && !timeout_q;
        timeout_o        = timeout_q;
        err_count_o      = err_cnt_q;
        first_err_addr_o = first_err_q;
    end
endmodule
